// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receive path and later UART blocks.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FIFO_DEPTH = 16;

    // Occupancy needs one extra bit so a full FIFO (count == depth) is representable.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit, with a configurable reset value.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: turns each rising edge of the UART byte-done strobe into one push of rx_data
// into a show-ahead FIFO with sticky overflow reporting.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = UART_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_status,
    input  logic [UART_DATA_W-1:0]        rx_data,
    output logic [UART_DATA_W-1:0]        out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic                   rx_sync;
    logic                   rx_prev;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   ovf_set;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [UART_DATA_W-1:0] mem [DEPTH];

    // Flops reset high so a strobe already high when reset releases is not seen as an edge.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_status),
        .q   (rx_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_sync;
        end
    end

    assign push      = rx_sync & ~rx_prev;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == FULL_COUNT);
    // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
    assign wr_en     = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, is the FIFO entry count and SHALL be a power of two, minimum 2.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchroniser flops on rx_status and SHALL be at least 2.
REQ-003 clk  input  1  is the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-high.
REQ-005 rx_status  input  1  is the byte-done pulse from the UART receiver, asynchronous to clk, high for at least one receiver baud-tick.
REQ-006 rx_data  input  8  is the received byte, LSB-first assembled, stable for at least one bit period after rx_status rises.
REQ-007 out_data  output  8  is the byte at the FIFO head; it is valid only while out_valid=1.
REQ-008 out_valid  output  1  SHALL be high when the FIFO holds at least one byte.
REQ-009 out_ready  input  1  is the consumer accept signal; a pop occurs on a cycle with out_valid=1 and out_ready=1.
REQ-010 count  output  $clog2(DEPTH)+1  is the current occupancy, range 0..DEPTH.
REQ-011 overflow  output  1  is a sticky flag marking that at least one byte was dropped.
REQ-012 clr_ovf  input  1  clears overflow when high for one cycle.

Function
REQ-013 rx_status SHALL pass through a SYNC_STAGES-flop chain, and one further flop SHALL hold its previous synchronised value.
REQ-014 A push event SHALL be asserted for exactly one clk cycle on each 0->1 transition of the synchronised rx_status, and never more than once per pulse.
REQ-015 On a push event, rx_data SHALL be written to mem[wr_ptr], and wr_ptr SHALL increment modulo DEPTH.
REQ-016 Latency: with the FIFO empty, out_valid SHALL rise one cycle after the push-event cycle, and out_data SHALL equal the pushed byte in that cycle.
REQ-017 The FIFO is show-ahead: out_data SHALL be mem[rd_ptr] at all times, with no read latency.
REQ-018 On a pop, rd_ptr SHALL increment modulo DEPTH, and the next entry SHALL appear on out_data in the following cycle.
REQ-019 A pop while out_valid=0 SHALL be ignored; pointers and count SHALL be unchanged.
REQ-020 count SHALL update as follows: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-021 A push when count=DEPTH with no pop in the same cycle SHALL drop the byte, leave mem, wr_ptr and count unchanged, and set overflow.
REQ-022 A push when count=DEPTH with a pop in the same cycle SHALL be accepted, and overflow SHALL NOT be set.
REQ-023 If clr_ovf and an overflow event occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no loss or duplication of data.
REQ-025 out_valid SHALL equal (count != 0), decoded from registered count with no combinational path from out_ready.

Reset
REQ-026 While rst=1: wr_ptr=0, rd_ptr=0, count=0, overflow=0, out_valid=0.
REQ-027 While rst=1, all synchroniser and edge-history flops SHALL be 1, so that rx_status held high across reset release produces no push.
REQ-028 Memory contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-029 Reset asserted mid-transfer SHALL discard all stored bytes immediately; the first push after release SHALL land at entry 0.

Structure
REQ-030 Package uart_pkg SHALL hold UART_DATA_W=8, the default FIFO depth, and the count-width function.
REQ-031 The synchroniser SHALL be a separate sub-module, sync_ff (parameterised stage count and reset value), reused by later UART blocks.
REQ-032 Storage SHALL be a flop or distributed-RAM array with one write port and one asynchronous read port.

Verification
REQ-033 After reset, pulse rx_status with rx_data=0x41, out_ready=0 -> out_valid=1 two to four cycles later, out_data=0x41, count=1.
REQ-034 Hold rx_status high for 20 clk cycles with rx_data=0x55 -> exactly one push; count=1.
REQ-035 Push 16 bytes 0x00..0x0F, then push 0xAA with out_ready=0 -> count=16, overflow=1; pop all -> sequence 0x00..0x0F in order, 0xAA absent.
REQ-036 At count=16, push 0xBB on the same cycle as a pop -> count stays 16, overflow stays 0, 0xBB is the last byte popped.
REQ-037 Push 20 bytes with out_ready=1 continuously across pointer wrap -> all 20 bytes out in order, count never exceeds 1.
REQ-038 Assert rst with count=5 and rx_status=1, release while rx_status stays 1 -> count=0, out_valid=0, no push until the next rising edge of rx_status.
